// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared definitions for the sprite motion path: PS/2 scan codes, direction
// encoding, decoder states and the small arrow-key helper functions.
package pacman_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    function automatic logic is_arrow(input logic [7:0] code);
        return (code == KEY_UP) || (code == KEY_DOWN) ||
               (code == KEY_LEFT) || (code == KEY_RIGHT);
    endfunction

    function automatic logic [1:0] arrow_dir(input logic [7:0] code);
        logic [1:0] d;
        case (code)
            KEY_UP:    d = DIR_UP;
            KEY_DOWN:  d = DIR_DOWN;
            KEY_LEFT:  d = DIR_LEFT;
            KEY_RIGHT: d = DIR_RIGHT;
            default:   d = DIR_UP;
        endcase
        return d;
    endfunction

    // Fallback choice when the active key is released: up > down > left > right.
    function automatic logic [1:0] prio_dir(input logic [3:0] mask);
        logic [1:0] d;
        if (mask[0])      d = DIR_UP;
        else if (mask[1]) d = DIR_DOWN;
        else if (mask[2]) d = DIR_LEFT;
        else              d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Keyboard byte input and sprite position/direction outputs of the motion controller.
interface sprite_motion_ctrl_if;
    logic [7:0] ps2_byte;
    logic       ps2_valid;
    logic [9:0] x_loc;
    logic [8:0] y_loc;
    logic       moving;
    logic [1:0] dir;
    logic       step_tick;

    modport master (
        output ps2_byte, ps2_valid,
        input  x_loc, y_loc, moving, dir, step_tick
    );

    modport slave (
        input  ps2_byte, ps2_valid,
        output x_loc, y_loc, moving, dir, step_tick
    );
endinterface

// File: rtl/sprite_motion_ctrl_ps2_arrow_decoder.sv
// Turns the PS/2 byte stream into registered one-cycle make/break events for
// the four arrow keys; prefixed and numpad forms decode identically.
module ps2_arrow_decoder
    import pacman_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_valid,
    output logic       make_evt,
    output logic       break_evt,
    output logic [1:0] key_dir
);

    dec_state_e state_q;
    logic       make_q;
    logic       break_q;
    logic [1:0] key_q;
    logic       arrow_s;

    assign arrow_s = is_arrow(ps2_byte);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            make_q  <= 1'b0;
            break_q <= 1'b0;
            key_q   <= DIR_UP;
        end else begin
            make_q  <= 1'b0;
            break_q <= 1'b0;
            if (ps2_valid) begin
                case (state_q)
                    ST_IDLE, ST_EXT: begin
                        if (arrow_s) begin
                            make_q  <= 1'b1;
                            key_q   <= arrow_dir(ps2_byte);
                            state_q <= ST_IDLE;
                        end else if (ps2_byte == SC_E0) begin
                            state_q <= ST_EXT;
                        end else if (ps2_byte == SC_F0) begin
                            state_q <= (state_q == ST_IDLE) ? ST_BRK : ST_EXT_BRK;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    // Repeated prefixes inside a break keep waiting for the key byte.
                    ST_BRK, ST_EXT_BRK: begin
                        if (arrow_s) begin
                            break_q <= 1'b1;
                            key_q   <= arrow_dir(ps2_byte);
                            state_q <= ST_IDLE;
                        end else if ((ps2_byte == SC_E0) || (ps2_byte == SC_F0)) begin
                            state_q <= state_q;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign make_evt  = make_q;
    assign break_evt = break_q;
    assign key_dir   = key_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Held-arrow tracking, most-recent-key direction arbitration, fixed-rate step
// timer and edge-clamped sprite position for the VGA box renderer.
module sprite_motion_ctrl
    import pacman_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int STEP_DIV = 2097152,
    parameter int STEP_PX  = 1
)
(
    input logic                 vga_clk,
    input logic                 reset,
    sprite_motion_ctrl_if.slave bus
);

    localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(STEP_DIV - 2);
    localparam logic signed [10:0] STEP_X  = 11'(STEP_PX);
    localparam logic signed [9:0]  STEP_Y  = 10'(STEP_PX);
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - SPRITE_W);
    localparam logic signed [9:0]  Y_MAX   = 10'(SCREEN_H - SPRITE_H);

    logic       make_s, break_s;
    logic [1:0] key_s;

    logic [3:0]       mask_q, mask_d;
    logic [1:0]       dir_q, dir_d;
    logic             moving_q, moving_d;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;

    logic signed [10:0] x_dec_s, x_inc_s;
    logic signed [9:0]  y_dec_s, y_inc_s;

    ps2_arrow_decoder u_dec (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .ps2_byte  (bus.ps2_byte),
        .ps2_valid (bus.ps2_valid),
        .make_evt  (make_s),
        .break_evt (break_s),
        .key_dir   (key_s)
    );

    // Held mask and active direction; only releasing the active key re-arbitrates.
    always_comb begin
        mask_d   = mask_q;
        dir_d    = dir_q;
        moving_d = moving_q;
        if (make_s) begin
            mask_d[key_s] = 1'b1;
            dir_d         = key_s;
            moving_d      = 1'b1;
        end else if (break_s) begin
            mask_d[key_s] = 1'b0;
            if (moving_q && (key_s == dir_q)) begin
                if (mask_d != 4'b0000) begin
                    dir_d    = prio_dir(mask_d);
                    moving_d = 1'b1;
                end else begin
                    dir_d    = DIR_UP;
                    moving_d = 1'b0;
                end
            end else begin
                dir_d = dir_q;
            end
        end else begin
            mask_d = mask_q;
        end
    end

    // Clamped step arithmetic, widened and signed so neither edge can wrap.
    always_comb begin
        x_dec_s = $signed({1'b0, x_q}) - STEP_X;
        x_inc_s = $signed({1'b0, x_q}) + STEP_X;
        y_dec_s = $signed({1'b0, y_q}) - STEP_Y;
        y_inc_s = $signed({1'b0, y_q}) + STEP_Y;
        x_d     = x_q;
        y_d     = y_q;
        if (tick_q && moving_q) begin
            case (dir_q)
                DIR_UP:    y_d = (y_dec_s < 10'sd0) ? 9'd0 : y_dec_s[8:0];
                DIR_DOWN:  y_d = (y_inc_s > Y_MAX) ? Y_MAX[8:0] : y_inc_s[8:0];
                DIR_LEFT:  x_d = (x_dec_s < 11'sd0) ? 10'd0 : x_dec_s[9:0];
                DIR_RIGHT: x_d = (x_inc_s > X_MAX) ? X_MAX[9:0] : x_inc_s[9:0];
                default:   x_d = x_q;
            endcase
        end else begin
            x_d = x_q;
        end
    end

    // State registers; tick is registered one cycle ahead so it lines up with CNT_LAST.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            mask_q   <= 4'b0000;
            dir_q    <= DIR_UP;
            moving_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            tick_q   <= 1'b0;
            x_q      <= 10'd0;
            y_q      <= 9'd0;
        end else begin
            mask_q   <= mask_d;
            dir_q    <= dir_d;
            moving_q <= moving_d;
            cnt_q    <= (cnt_q == CNT_LAST) ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1'b1);
            tick_q   <= (cnt_q == CNT_PRE);
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign bus.x_loc     = x_q;
    assign bus.y_loc     = y_q;
    assign bus.moving    = moving_q;
    assign bus.dir       = dir_q;
    assign bus.step_tick = tick_q;

endmodule
